// File: rtl/duty_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | duty_ctrl_pkg : duty-select encodings, FSM states and sizing helpers     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package duty_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_MANUAL    = 2'b00,
      ST_AUTO_UP   = 2'b01,
      ST_AUTO_DOWN = 2'b10
   } duty_state_t;

   localparam logic [1:0] DUTY_25  = 2'b00;
   localparam logic [1:0] DUTY_50  = 2'b01;
   localparam logic [1:0] DUTY_75  = 2'b10;
   localparam logic [1:0] DUTY_100 = 2'b11;

   function automatic int unsigned cycles_for_ms(input int unsigned clk_freq,
                                                 input int unsigned ms);
      return clk_freq / 1000 * ms;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_debounce : 2-FF synchronizer, stability debouncer, press pulse       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module btn_debounce
   import duty_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYC = 10
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned       CNT_W    = cnt_width(DB_CYC);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYC - 1);

   logic             sync_1;
   logic             sync_2;
   logic             db;
   logic             db_prev;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         db      <= 1'b0;
         db_prev <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= btn_raw;
         sync_2  <= sync_1;
         db_prev <= db;
         if (sync_2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db  <= sync_2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Rising edge of the debounced level only; releases are silent.
   assign press = db & ~db_prev;

endmodule
`default_nettype wire

// File: rtl/duty_sel_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | duty_sel_controller : button-driven duty select with auto ping-pong sweep|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module duty_sel_controller
   import duty_ctrl_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 100_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned STEP_MS     = 1000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_mode,
   input  logic       enable,
   output logic [1:0] duty_sel,
   output logic       auto_active,
   output logic       sel_changed
);

   localparam int unsigned       DB_CYC    = cycles_for_ms(CLK_FREQ, DEBOUNCE_MS);
   localparam int unsigned       STEP_CYC  = cycles_for_ms(CLK_FREQ, STEP_MS);
   localparam int unsigned       STEP_W    = cnt_width(STEP_CYC);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);

   logic              press_up;
   logic              press_down;
   logic              press_mode;
   logic              ev_up;
   logic              ev_down;
   logic              ev_mode;
   duty_state_t       state;
   duty_state_t       state_nx;
   logic [1:0]        duty;
   logic [1:0]        duty_nx;
   logic [STEP_W-1:0] step_cnt;
   logic [STEP_W-1:0] step_nx;

   btn_debounce #(.DB_CYC(DB_CYC)) u_db_up (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_up),
      .press   (press_up)
   );

   btn_debounce #(.DB_CYC(DB_CYC)) u_db_down (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_down),
      .press   (press_down)
   );

   btn_debounce #(.DB_CYC(DB_CYC)) u_db_mode (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_mode),
      .press   (press_mode)
   );

   assign ev_up   = enable & press_up;
   assign ev_down = enable & press_down;
   assign ev_mode = enable & press_mode;

   always_comb begin
      state_nx = state;
      duty_nx  = duty;
      step_nx  = step_cnt;
      if (enable) begin
         case (state)
            ST_MANUAL: begin
               step_nx = '0;
               if (ev_mode) begin
                  state_nx = (duty == DUTY_100) ? ST_AUTO_DOWN : ST_AUTO_UP;
               end else if (ev_up && !ev_down && duty != DUTY_100) begin
                  duty_nx = duty + 2'd1;
               end else if (ev_down && !ev_up && duty != DUTY_25) begin
                  duty_nx = duty - 2'd1;
               end
            end
            ST_AUTO_UP, ST_AUTO_DOWN: begin
               // Any press leaves the sweep and swallows a coincident step.
               if (ev_mode || ev_up || ev_down) begin
                  state_nx = ST_MANUAL;
                  step_nx  = '0;
               end else if (step_cnt == STEP_LAST) begin
                  step_nx = '0;
                  if (state == ST_AUTO_UP) begin
                     if (duty != DUTY_100) duty_nx = duty + 2'd1;
                     if (duty_nx == DUTY_100) state_nx = ST_AUTO_DOWN;
                  end else begin
                     if (duty != DUTY_25) duty_nx = duty - 2'd1;
                     if (duty_nx == DUTY_25) state_nx = ST_AUTO_UP;
                  end
               end else begin
                  step_nx = step_cnt + STEP_W'(1);
               end
            end
            default: begin
               state_nx = ST_MANUAL;
               step_nx  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_MANUAL;
         duty        <= DUTY_25;
         step_cnt    <= '0;
         sel_changed <= 1'b0;
      end else begin
         state       <= state_nx;
         duty        <= duty_nx;
         step_cnt    <= step_nx;
         sel_changed <= (duty_nx != duty);
      end
   end

   assign duty_sel    = duty;
   assign auto_active = (state == ST_AUTO_UP) || (state == ST_AUTO_DOWN);

endmodule
`default_nettype wire

// File: tb/tb_duty_sel_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_duty_sel_controller : directed bench with a behavioural output model  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_duty_sel_controller;

   localparam int DB_CYC   = 10;
   localparam int STEP_CYC = 20;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic       btn_mode = 1'b0;
   logic       enable = 1'b1;
   logic [1:0] duty_sel;
   logic       auto_active;
   logic       sel_changed;

   int n_total = 0;
   int n_pass  = 0;

   duty_sel_controller #(
      .CLK_FREQ    (10_000),
      .DEBOUNCE_MS (1),
      .STEP_MS     (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_mode    (btn_mode),
      .enable      (enable),
      .duty_sel    (duty_sel),
      .auto_active (auto_active),
      .sel_changed (sel_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model. The debounced level flips once the last DB_CYC
   // synchronized samples (raw delayed two clocks) all disagree with it.
   logic [DB_CYC:0] m_hist [3];
   logic            m_db   [3];
   logic            m_pend [3];
   int              m_duty, m_mode, m_timer;   // mode: 0 manual, 1 up, 2 down
   logic            m_chg;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < 3; b++) begin
            m_hist[b] <= '0;
            m_db[b]   <= 1'b0;
            m_pend[b] <= 1'b0;
         end
         m_duty  <= 0;
         m_mode  <= 0;
         m_timer <= 0;
         m_chg   <= 1'b0;
      end else begin : model_step
         logic [2:0] raw;
         logic       flip;
         logic       up, dn, mo;
         int         d, md, t;
         raw = {btn_mode, btn_down, btn_up};
         for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            for (int j = 1; j <= DB_CYC; j++)
               if (m_hist[b][j] == m_db[b]) flip = 1'b0;
            m_pend[b] <= flip & ~m_db[b];
            if (flip) m_db[b] <= ~m_db[b];
            m_hist[b] <= {m_hist[b][DB_CYC-1:0], raw[b]};
         end
         up = m_pend[0]; dn = m_pend[1]; mo = m_pend[2];
         d = m_duty; md = m_mode; t = m_timer;
         if (enable) begin
            if (md == 0) begin
               if (mo) begin md = (d == 3) ? 2 : 1; t = 0; end
               else if (up && !dn) d = (d < 3) ? d + 1 : d;
               else if (dn && !up) d = (d > 0) ? d - 1 : d;
            end else if (mo || up || dn) begin
               md = 0; t = 0;
            end else if (t == STEP_CYC - 1) begin
               t = 0;
               if (md == 1) begin d = d + 1; if (d == 3) md = 2; end
               else         begin d = d - 1; if (d == 0) md = 1; end
            end else begin
               t = t + 1;
            end
         end
         m_chg   <= (d != m_duty);
         m_duty  <= d;
         m_mode  <= md;
         m_timer <= t;
      end
   end

   always @(negedge clk) begin
      check("duty_sel",    int'(duty_sel),    m_duty);
      check("auto_active", int'(auto_active), (m_mode != 0) ? 1 : 0);
      check("sel_changed", int'(sel_changed), int'(m_chg));
   end

   task automatic press_btn(input int b, input int hold, input int gap);
      case (b)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         default: btn_mode = 1'b1;
      endcase
      repeat (hold) @(negedge clk);
      btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_sel(input int budget, output int cyc);
      cyc = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (sel_changed) begin cyc = i; break; end
      end
      if (cyc < 0) check("sel_changed_timeout", 0, 1);
   endtask

   task automatic wait_auto(input int budget);
      int seen;
      seen = 0;
      for (int i = 0; i < budget && seen == 0; i++) begin
         @(negedge clk);
         if (auto_active) seen = 1;
      end
      check("auto_active_timeout", seen, 1);
   endtask

   initial begin
      int cyc;
      int exp_seq [7] = '{2, 3, 2, 1, 0, 1, 2};

      repeat (3) @(negedge clk);
      check("reset_duty", int'(duty_sel), 0);
      check("reset_auto", int'(auto_active), 0);
      check("reset_chg",  int'(sel_changed), 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // First press: change lands exactly DB_CYC+3 cycles after the raw rise.
      btn_up = 1'b1;
      repeat (12) @(negedge clk);
      check("press_latency_before", int'(duty_sel), 0);
      @(negedge clk);
      check("press_latency_at", int'(duty_sel), 1);
      check("press_pulse", int'(sel_changed), 1);
      @(negedge clk);
      check("press_pulse_single", int'(sel_changed), 0);
      repeat (16) @(negedge clk);
      btn_up = 1'b0;
      repeat (20) @(negedge clk);
      repeat (4) press_btn(0, 15, 15);
      check("up_saturate", int'(duty_sel), 3);

      // Bounce shorter than the debounce window never registers.
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) btn_up = ~btn_up;
         @(negedge clk);
      end
      btn_up = 1'b0;
      repeat (20) @(negedge clk);
      check("bounce_rejected", int'(duty_sel), 3);

      repeat (2) press_btn(1, 15, 15);
      check("down_twice", int'(duty_sel), 1);

      // Auto sweep ping-pong.
      btn_mode = 1'b1;
      repeat (14) @(negedge clk);
      btn_mode = 1'b0;
      check("mode_enter_auto", int'(auto_active), 1);
      check("mode_keeps_duty", int'(duty_sel), 1);
      for (int k = 0; k < 7; k++) begin
         wait_sel(25, cyc);
         check("sweep_value", int'(duty_sel), exp_seq[k]);
         if (k > 0) check("sweep_period", cyc, STEP_CYC);
      end

      // Down press in AUTO_UP at 10 returns to manual with value kept.
      btn_down = 1'b1;
      repeat (14) @(negedge clk);
      btn_down = 1'b0;
      check("down_exit_auto", int'(auto_active), 0);
      check("down_exit_duty", int'(duty_sel), 2);
      repeat (60) @(negedge clk);
      check("no_step_in_manual", int'(duty_sel), 2);

      // Enable low freezes the step timer mid-count.
      btn_mode = 1'b1;
      wait_auto(20);
      repeat (8) @(negedge clk);
      btn_mode = 1'b0;
      enable = 1'b0;
      repeat (50) @(negedge clk);
      check("frozen_duty", int'(duty_sel), 2);
      check("frozen_auto", int'(auto_active), 1);
      enable = 1'b1;
      wait_sel(30, cyc);
      check("resume_remaining", cyc, 12);
      check("resume_value", int'(duty_sel), 3);

      btn_mode = 1'b1;
      repeat (14) @(negedge clk);
      btn_mode = 1'b0;
      check("mode_exit_auto", int'(auto_active), 0);
      check("mode_exit_duty", int'(duty_sel), 3);
      repeat (20) @(negedge clk);
      press_btn(1, 15, 15);
      check("manual_down", int'(duty_sel), 2);
      btn_up = 1'b1; btn_down = 1'b1;
      repeat (15) @(negedge clk);
      btn_up = 1'b0; btn_down = 1'b0;
      repeat (20) @(negedge clk);
      check("up_down_ignored", int'(duty_sel), 2);

      // Asynchronous reset in the middle of a sweep at 11.
      btn_mode = 1'b1;
      wait_auto(20);
      btn_mode = 1'b0;
      wait_sel(25, cyc);
      check("sweep_to_top", int'(duty_sel), 3);
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_duty", int'(duty_sel), 0);
      check("async_rst_auto", int'(auto_active), 0);
      check("async_rst_chg",  int'(sel_changed), 0);
      btn_up = 1'b1;
      repeat (3) @(negedge clk);

      // Button held across reset release yields exactly one press.
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("held_release_before", int'(duty_sel), 0);
      @(negedge clk);
      check("held_release_at", int'(duty_sel), 1);
      repeat (30) @(negedge clk);
      btn_up = 1'b0;
      repeat (40) @(negedge clk);
      check("held_release_once", int'(duty_sel), 1);
      check("no_sweep_after_rst", int'(auto_active), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      n_total++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/duty_sel_controller.md
DUTY_SEL_CONTROLLER -- requirements
Module: duty_sel_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, button stable time in ms; DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS.
REQ-003 SHALL have parameter STEP_MS, default 1000, auto-sweep step period in ms; STEP_CYC = CLK_FREQ/1000*STEP_MS.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 btn_up  in  1  raw pushbutton, active-high, asynchronous to clk, bouncy.
REQ-007 btn_down  in  1  raw pushbutton, active-high, asynchronous, bouncy.
REQ-008 btn_mode  in  1  raw pushbutton, active-high, asynchronous; toggles manual/auto.
REQ-009 enable  in  1  synchronous; 0 freezes state, value and step timer.
REQ-010 duty_sel  out  2  00=25%, 01=50%, 10=75%, 11=100%; drives PWM and display driver.
REQ-011 auto_active  out  1  high while FSM is in AUTO_UP or AUTO_DOWN.
REQ-012 sel_changed  out  1  one-cycle pulse, high in the first cycle a new duty_sel value is visible.

Function
REQ-013 Each button SHALL pass through a 2-FF synchronizer then a debouncer: counter increments while synchronized value s differs from debounced value d, clears when equal; on reaching DB_CYC-1 with s!=d, d takes s and counter clears.
REQ-014 A press event SHALL be a one-cycle pulse in the first cycle d rises; releases generate no event.
REQ-015 duty_sel SHALL update on the edge after the press pulse: raw rise held stable -> duty_sel change exactly DB_CYC+3 cycles later.
REQ-016 FSM states SHALL be MANUAL, AUTO_UP, AUTO_DOWN.
REQ-017 MANUAL: up press increments duty_sel, saturating at 11; down press decrements, saturating at 00; saturated presses produce no change and no sel_changed.
REQ-018 MANUAL: up and down press in the same cycle SHALL be ignored.
REQ-019 MANUAL + mode press SHALL go to AUTO_DOWN if duty_sel==11, else AUTO_UP; step timer cleared; duty_sel unchanged.
REQ-020 AUTO_UP/AUTO_DOWN: step timer counts 0..STEP_CYC-1; at terminal count duty_sel steps +1 (AUTO_UP) or -1 (AUTO_DOWN) and timer wraps to 0.
REQ-021 AUTO_UP step reaching 11 SHALL transition to AUTO_DOWN on that edge; AUTO_DOWN step reaching 00 SHALL transition to AUTO_UP (ping-pong 00-01-10-11-10-01-00...).
REQ-022 AUTO states + mode press, or up/down press, SHALL return to MANUAL with duty_sel unchanged; the up/down press does not alter the value.
REQ-023 Priority in a single cycle: mode press > up/down press > step terminal count; a step coinciding with any press SHALL be discarded.
REQ-024 enable=0: press events discarded, step timer and FSM held; debouncers keep running; on enable=1 timer resumes from held value.
REQ-025 sel_changed SHALL be registered, asserted only when duty_sel value actually changes.

Reset
REQ-026 reset_n low SHALL asynchronously set: duty_sel=00, auto_active=0, sel_changed=0, FSM=MANUAL, step timer=0, debouncer counters=0, synchronizer and debounced values=0.
REQ-027 Reset release mid-press: a button held during release SHALL generate exactly one press after DB_CYC+3 cycles (debounced starts at 0).
REQ-028 Reset asserted mid-auto-sweep SHALL abandon the sweep with no further steps.

Structure
REQ-029 Package duty_ctrl_pkg SHALL hold FSM state encoding and constants DUTY_25=00, DUTY_50=01, DUTY_75=10, DUTY_100=11, shared with PWM and display blocks.
REQ-030 Sub-module btn_debounce (synchronizer + debouncer + press pulse, parameter DB_CYC) SHALL be instantiated three times; FSM, step timer and output registers live in the top.

Verification (CLK_FREQ=10_000, DEBOUNCE_MS=1, STEP_MS=2 -> DB_CYC=10, STEP_CYC=20)
REQ-031 Reset, btn_up raw high held 30 cycles -> duty_sel 00->01 exactly 13 cycles after rise, sel_changed single pulse; 4 more presses -> 10, 11, then saturates at 11 with no sel_changed.
REQ-032 btn_up toggling every 3 cycles for 40 cycles then low -> no press event, duty_sel unchanged.
REQ-033 duty_sel=01, mode press -> auto_active=1, steps every 20 cycles: 10, 11, 10, 01, 00, 01; each with one sel_changed pulse.
REQ-034 In AUTO_UP at duty_sel=10, down press -> MANUAL, auto_active=0, duty_sel stays 10, no step thereafter.
REQ-035 In AUTO_UP, enable=0 for 50 cycles -> no steps; enable=1 -> next step after remaining timer count; up+down press simultaneous in MANUAL -> no change.
REQ-036 reset_n pulsed low mid-sweep at duty_sel=11 -> all outputs 0 immediately (asynchronously), FSM MANUAL, no step after release.
